bus_toggle_arb: RTL and testbench

//  Two-requester scheduler for a shared 8-bit registered bus, budgeted on switching activity.
//  - Cost of a transfer = Hamming distance between the new message and the last driven bus value.
//  - Credits refill every cycle. A transfer issues only when the budget covers its cost.
//  - Max-switching transitions (0x55<->0xAA, cost 8) are therefore rate-limited.
//  - Sits between producers and the bus that the max-switching edge detector monitors.

---
 rtl/bus_toggle_arb_pkg.sv | 15 +
 rtl/bus_toggle_arb_if.sv | 23 ++
 rtl/bus_toggle_arb_toggle_cost_calc.sv | 16 +
 rtl/bus_toggle_arb.sv | 98 +++++++++
 tb/tb_bus_toggle_arb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_toggle_arb_pkg.sv
// Shared types and helpers for the switching-activity bus scheduler.
package bus_toggle_arb_pkg;
  localparam int NBITS = 8;

  typedef logic [NBITS-1:0] msg_t;

  function automatic logic [3:0] popcount8(input msg_t v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NBITS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction
endpackage

// File: rtl/bus_toggle_arb_if.sv
// Requester/bus handshake bundle; slave is the scheduler's view, master the producers'/bus side.
interface bus_toggle_arb_if;
  import bus_toggle_arb_pkg::*;

  logic in0_val;
  logic in0_rdy;
  msg_t in0_msg;
  logic in1_val;
  logic in1_rdy;
  msg_t in1_msg;
  logic out_val;
  msg_t out_msg;

  modport slave (
    input  in0_val, in0_msg, in1_val, in1_msg,
    output in0_rdy, in1_rdy, out_val, out_msg
  );

  modport master (
    output in0_val, in0_msg, in1_val, in1_msg,
    input  in0_rdy, in1_rdy, out_val, out_msg
  );
endinterface

// File: rtl/bus_toggle_arb_toggle_cost_calc.sv
// Switching cost of replacing bus value b with a: number of bit lanes that toggle.
module toggle_cost_calc
  import bus_toggle_arb_pkg::*;
(
  input  msg_t       a,
  input  msg_t       b,
  output logic [3:0] cost
);
  msg_t diff;

  for (genvar gi = 0; gi < NBITS; gi++) begin : g_diff
    assign diff[gi] = a[gi] ^ b[gi];
  end

  assign cost = popcount8(diff);
endmodule

// File: rtl/bus_toggle_arb.sv
// Two-requester bus scheduler that only issues a transfer when the toggle budget covers it.
// Optional build macro BUS_TOGGLE_ARB_STATS_EN adds a saturating stall-cycle counter output.
module bus_toggle_arb
  import bus_toggle_arb_pkg::*;
#(
  parameter int MAX_CREDITS = 16,
  parameter int REFILL      = 2,
  localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  bus_toggle_arb_if.slave bus,
  output logic [CW-1:0] credits,
  output logic          stall
`ifdef BUS_TOGGLE_ARB_STATS_EN
  ,
  output logic [15:0]   stall_count
`endif
);
  if (MAX_CREDITS < 8) begin : g_bad_max
    $error("bus_toggle_arb: MAX_CREDITS must be >= 8");
  end
  if (REFILL < 1 || REFILL > MAX_CREDITS) begin : g_bad_refill
    $error("bus_toggle_arb: REFILL must be in 1..MAX_CREDITS");
  end

  localparam logic [CW:0] MAX_W    = (CW + 1)'(MAX_CREDITS);
  localparam logic [CW:0] REFILL_W = (CW + 1)'(REFILL);

  msg_t          out_msg_reg;
  logic          out_val_reg;
  logic [CW-1:0] credits_reg;
  logic          prio_reg;

  logic          cand_val;
  logic          sel1;
  msg_t          cand_msg;
  logic [3:0]    cost;
  logic [CW:0]   cost_ext;
  logic [CW:0]   sum;
  logic          grant;
  logic [CW-1:0] credits_next;

  toggle_cost_calc u_cost (
    .a    (cand_msg),
    .b    (out_msg_reg),
    .cost (cost)
  );

  // Head-of-line: the prio requester, if valid, is the only candidate; no bypass on stall.
  always_comb begin
    cand_val     = bus.in0_val | bus.in1_val;
    sel1         = prio_reg ? bus.in1_val : !bus.in0_val;
    cand_msg     = sel1 ? bus.in1_msg : bus.in0_msg;
    cost_ext     = (CW + 1)'(cost);
    grant        = cand_val && ({1'b0, credits_reg} >= cost_ext);
    sum          = grant ? ({1'b0, credits_reg} - cost_ext + REFILL_W)
                         : ({1'b0, credits_reg} + REFILL_W);
    credits_next = (sum > MAX_W) ? MAX_W[CW-1:0] : sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_msg_reg <= '0;
      out_val_reg <= 1'b0;
      credits_reg <= MAX_W[CW-1:0];
      prio_reg    <= 1'b0;
    end else begin
      out_val_reg <= grant;
      credits_reg <= credits_next;
      if (grant) begin
        out_msg_reg <= cand_msg;
        prio_reg    <= !sel1;
      end
    end
  end

  assign bus.in0_rdy = grant && !sel1;
  assign bus.in1_rdy = grant && sel1;
  assign bus.out_val = out_val_reg;
  assign bus.out_msg = out_msg_reg;
  assign credits     = credits_reg;
  assign stall       = cand_val && !grant;

`ifdef BUS_TOGGLE_ARB_STATS_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (stall && stall_count_reg != 16'hFFFF) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count = stall_count_reg;
`endif
endmodule

// File: tb/tb_bus_toggle_arb.sv
// Directed + randomized bench for bus_toggle_arb against a toggle-budget reference model.
module tb_bus_toggle_arb;
  localparam int MAXC = 16;
  localparam int REF  = 2;

  logic       clk;
  logic       reset;
  logic [4:0] credits;
  logic       stall;
`ifdef BUS_TOGGLE_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  bus_toggle_arb_if bus_if ();

  bus_toggle_arb #(.MAX_CREDITS(MAXC), .REFILL(REF)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .credits     (credits),
    .stall       (stall)
`ifdef BUS_TOGGLE_ARB_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  // reference model state
  bit         m_known = 0;
  logic [7:0] m_bus;
  bit         m_oval;
  int         m_cred;
  bit         m_prio;
  int         m_scnt;

  // observed values from the latest step
  logic       obs_rdy0, obs_rdy1, obs_stall, obs_val;
  logic [7:0] obs_msg;
  int         obs_cred;

  task automatic chk(input string tag, input int obs, input int exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v0, input logic [7:0] m0,
                      input bit v1, input logic [7:0] m1);
    bit         any, pick1, grant, e_stall;
    logic [7:0] cmsg;
    int         cost;
    @(negedge clk);
    reset          = r;
    bus_if.in0_val = v0;
    bus_if.in0_msg = m0;
    bus_if.in1_val = v1;
    bus_if.in1_msg = m1;
    #1;
    any     = v0 | v1;
    pick1   = m_prio ? v1 : !v0;
    cmsg    = pick1 ? m1 : m0;
    cost    = $countones(cmsg ^ m_bus);
    grant   = any && (m_cred >= cost);
    e_stall = any && !grant;
    obs_rdy0  = bus_if.in0_rdy;
    obs_rdy1  = bus_if.in1_rdy;
    obs_stall = stall;
    obs_val   = bus_if.out_val;
    obs_msg   = bus_if.out_msg;
    obs_cred  = int'(credits);
    if (m_known) begin
      chk("in0_rdy", int'(obs_rdy0), int'(grant && !pick1));
      chk("in1_rdy", int'(obs_rdy1), int'(grant && pick1));
      chk("stall", int'(obs_stall), int'(e_stall));
      chk("out_val", int'(obs_val), int'(m_oval));
      chk("out_msg", int'(obs_msg), int'(m_bus));
      chk("credits", obs_cred, m_cred);
`ifdef BUS_TOGGLE_ARB_STATS_EN
      chk("stall_count", int'(stall_count), m_scnt);
`endif
    end
    @(posedge clk);
    if (r) begin
      m_known = 1;
      m_bus   = 8'h00;
      m_oval  = 0;
      m_cred  = MAXC;
      m_prio  = 0;
      m_scnt  = 0;
    end else if (m_known) begin
      if (e_stall && m_scnt < 65535) m_scnt++;
      m_oval = grant;
      if (grant) begin
        m_bus  = cmsg;
        m_prio = !pick1;
        m_cred = m_cred - cost + REF;
      end else begin
        m_cred = m_cred + REF;
      end
      if (m_cred > MAXC) m_cred = MAXC;
    end
  endtask

  function automatic logic [7:0] pick_msg();
    case ($urandom_range(0, 5))
      0: return 8'h55;
      1: return 8'hAA;
      2: return 8'h00;
      3: return 8'hFF;
      4: return m_bus;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bit         v0, v1, r, got;
    logic [7:0] m0, m1;

    reset = 1'b0;
    bus_if.in0_val = 1'b0;
    bus_if.in0_msg = '0;
    bus_if.in1_val = 1'b0;
    bus_if.in1_msg = '0;

    // 1: reset, idle
    step(1, 0, 8'h00, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00);
    chk("t1_credits", obs_cred, 16);
    chk("t1_out_msg", int'(obs_msg), 0);
    chk("t1_out_val", int'(obs_val), 0);
    chk("t1_stall", int'(obs_stall), 0);

    // 2: single transfer
    step(0, 1, 8'h55, 0, 8'h00);
    chk("t2_rdy0", int'(obs_rdy0), 1);
    step(0, 0, 8'h00, 0, 8'h00);
    chk("t2_out_msg", int'(obs_msg), 8'h55);
    chk("t2_out_val", int'(obs_val), 1);
    chk("t2_credits", obs_cred, 14);

    // 3: both valid, alternation
    step(1, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h01, 1, 8'h02);
    chk("t3_rdy0", int'(obs_rdy0), 1);
    chk("t3_rdy1_lose", int'(obs_rdy1), 0);
    step(0, 0, 8'h00, 1, 8'h02);
    chk("t3_rdy1", int'(obs_rdy1), 1);
    chk("t3_msg_a", int'(obs_msg), 8'h01);
    chk("t3_cred_a", obs_cred, 16);
    step(0, 0, 8'h00, 0, 8'h00);
    chk("t3_msg_b", int'(obs_msg), 8'h02);
    chk("t3_cred_b", obs_cred, 16);

    // 4: max-switching stream
    step(1, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h55, 0, 8'h00);
    step(0, 1, 8'hAA, 0, 8'h00);
    step(0, 1, 8'h55, 0, 8'h00);
    chk("t4_cred_pre", obs_cred, 8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hAA, 0, 8'h00);
      chk("t4_stall", int'(obs_stall), 1);
      chk("t4_stall_cred", obs_cred, 2 + 2 * i);
    end
    step(0, 1, 8'hAA, 0, 8'h00);
    chk("t4_grant", int'(obs_rdy0), 1);
    step(0, 0, 8'h00, 0, 8'h00);
    chk("t4_cred_post", obs_cred, 2);
    chk("t4_msg", int'(obs_msg), 8'hAA);

    // 5: head-of-line blocking (bus 55, credits 2, prio in0)
    step(1, 0, 8'h00, 0, 8'h00);
    step(0, 0, 8'h00, 1, 8'h55);
    step(0, 1, 8'hAA, 0, 8'h00);
    step(0, 0, 8'h00, 1, 8'h55);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hAA, 1, 8'h55);
      chk("t5_hol_rdy1", int'(obs_rdy1), 0);
      chk("t5_hol_stall", int'(obs_stall), 1);
    end
    step(0, 1, 8'hAA, 1, 8'h55);
    chk("t5_rdy0", int'(obs_rdy0), 1);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0, 0, 8'h00, 1, 8'h55);
      got = obs_rdy1;
    end
    chk("t5_in1_eventually", int'(got), 1);

    // 6: reset in the middle of a stall
    step(1, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h55, 0, 8'h00);
    step(0, 1, 8'hAA, 0, 8'h00);
    step(0, 1, 8'h55, 0, 8'h00);
    step(0, 1, 8'hAA, 0, 8'h00);
    chk("t6_pre_stall", int'(obs_stall), 1);
    step(1, 1, 8'hAA, 0, 8'h00);
    step(0, 1, 8'h01, 1, 8'h02);
    chk("t6_credits", obs_cred, 16);
    chk("t6_out_msg", int'(obs_msg), 0);
    chk("t6_out_val", int'(obs_val), 0);
    chk("t6_prio", int'(obs_rdy0), 1);
`ifdef BUS_TOGGLE_ARB_STATS_EN
    chk("t6_stall_count", int'(stall_count), 0);
`endif

    // randomized traffic; producers hold a message until it is accepted
    v0 = 0; v1 = 0; m0 = '0; m1 = '0;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      step(r, v0, m0, v1, m1);
      if (!v0 || (obs_rdy0 && !r)) begin
        v0 = ($urandom_range(0, 2) != 0);
        m0 = pick_msg();
      end
      if (!v1 || (obs_rdy1 && !r)) begin
        v1 = ($urandom_range(0, 2) != 0);
        m1 = pick_msg();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end
endmodule
